datapath_ctrl: RTL

Multicycle control unit that sequences the 64-bit add/sub/load/store datapath. Accepts one 32-bit RV64 instruction at a time over a valid/ready handshake and decodes ADD, SUB, ADDI, LD and SD. Drives the datapath's register selects, immediate, ALU and mux selects and write enables state by state. Flags unsupported encodings and, optionally, counts retired instructions.

---
 rtl/datapath_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/datapath_ctrl.sv
// Multicycle controller for the 64-bit add/sub/load/store datapath (ADD, SUB, ADDI, LD, SD).
// Define DATAPATH_CTRL_RETIRE_CNT_EN to build the retired-instruction counter.
//
// state  | meaning
// IDLE   | instr_ready high, waiting for an instruction
// DECODE | IR classified; illegal pulses here for unsupported encodings
// EXEC   | ALU inputs settle, no write enables
// MEM    | LD: memory read; SD: WE_MEM and done
// WB     | WE_RF (suppressed for rd==0) and done
module datapath_ctrl (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] immediate,
  output logic        sub,
  output logic        WE_RF,
  output logic        WE_MEM,
  output logic        RF_din_sel,
  output logic        ULA_din2_sel,
  output logic        done,
  output logic        illegal,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_ADD, C_SUB, C_ADDI, C_LD, C_SD, C_ILL} cls_t;

  function automatic cls_t classify(input logic [31:0] w);
    cls_t c;
    c = C_ILL;
    if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0000000) c = C_ADD;
    else if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0100000) c = C_SUB;
    else if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) c = C_ADDI;
    else if (w[6:0] == 7'b0000011 && w[14:12] == 3'b011) c = C_LD;
    else if (w[6:0] == 7'b0100011 && w[14:12] == 3'b011) c = C_SD;
    return c;
  endfunction

  state_t      state;
  logic [31:0] ir;
  cls_t        ir_cls;
  cls_t        new_cls;

  assign ir_cls  = classify(ir);
  assign new_cls = classify(instr);

  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign rd        = ir[11:7];
  assign immediate = (ir_cls == C_SD) ? {ir[31:25], ir[11:7]} : ir[31:20];

  // Ready is gated by the reset pin so it is low for the whole reset interval.
  assign instr_ready = (state == S_IDLE) && RST_N;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      ir           <= '0;
      sub          <= 1'b0;
      ULA_din2_sel <= 1'b0;
      RF_din_sel   <= 1'b0;
      WE_RF        <= 1'b0;
      WE_MEM       <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      WE_RF   <= 1'b0;
      WE_MEM  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir           <= instr;
            state        <= S_DECODE;
            illegal      <= (new_cls == C_ILL);
            sub          <= (new_cls == C_SUB);
            ULA_din2_sel <= (new_cls == C_ADDI) || (new_cls == C_LD) || (new_cls == C_SD);
            RF_din_sel   <= (new_cls != C_LD);
          end
        end
        S_DECODE: begin
          if (ir_cls == C_ILL) begin
            state        <= S_IDLE;
            sub          <= 1'b0;
            ULA_din2_sel <= 1'b0;
            RF_din_sel   <= 1'b0;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ir_cls == C_LD) begin
            state <= S_MEM;
          end else if (ir_cls == C_SD) begin
            state  <= S_MEM;
            WE_MEM <= 1'b1;
            done   <= 1'b1;
          end else begin
            state <= S_WB;
            WE_RF <= (ir[11:7] != 5'd0);
            done  <= 1'b1;
          end
        end
        S_MEM: begin
          if (ir_cls == C_LD) begin
            state <= S_WB;
            WE_RF <= (ir[11:7] != 5'd0);
            done  <= 1'b1;
          end else begin
            state        <= S_IDLE;
            sub          <= 1'b0;
            ULA_din2_sel <= 1'b0;
            RF_din_sel   <= 1'b0;
          end
        end
        S_WB: begin
          state        <= S_IDLE;
          sub          <= 1'b0;
          ULA_din2_sel <= 1'b0;
          RF_din_sel   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DATAPATH_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) retire_q <= '0;
    else if (done) retire_q <= retire_q + 32'd1;
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule
